// File: rtl/fwd_pkg.sv
// Shared forwarding definitions for the MIPS datapath.
// Select encodings and default operand width.
package fwd_pkg;

  localparam int DATA_W = 32;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_SEL_REGFILE = 2'd0;
  localparam fwd_sel_t FWD_SEL_EXMEM   = 2'd1;
  localparam fwd_sel_t FWD_SEL_MEMWB   = 2'd2;

endpackage

// File: rtl/mux_nway.sv
// Combinational N-way mux; in_range flags sel < NUM_IN.
// Ports: in_data (flattened), sel -> data, in_range.
module mux_nway
  import fwd_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    in_range
);

  localparam logic [SEL_W:0] LIMIT = NUM_IN[SEL_W:0];

  always_comb begin
    data     = '0;
    in_range = ({1'b0, sel} < LIMIT);
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i))
        data = in_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/fwd_sel_pipe.sv
// Registered N-way operand forwarding stage with valid/ready,
// flush, and out-of-range select error tracking.
module fwd_sel_pipe
  import fwd_pkg::*;
#(
  parameter int WIDTH        = DATA_W,
  parameter int NUM_IN       = 3,
  parameter int SEL_W        = $clog2(NUM_IN),
  parameter bit HOLD_INVALID = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr,
  output logic [CNT_W-1:0]        err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] mux_data;
  logic             in_range;
  logic [WIDTH-1:0] last_good;
  logic [WIDTH-1:0] bad_data;
  logic             acc;
  logic             bad;

  mux_nway #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .data    (mux_data),
    .in_range(in_range)
  );

  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready && !flush;
  assign bad      = acc && !in_range;
  assign bad_data = HOLD_INVALID ? last_good : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      last_good <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      if (in_range) begin
        out_data  <= mux_data;
        last_good <= mux_data;
      end else begin
        out_data  <= bad_data;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A new error in the clearing cycle restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else if (bad) begin
      sel_err <= 1'b1;
      if (err_clr)
        err_count <= CNT_W'(1);
      else if (err_count != CNT_MAX)
        err_count <= err_count + CNT_W'(1);
    end else if (err_clr) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Directed bench for fwd_sel_pipe, plus HOLD_INVALID=0
// and NUM_IN/WIDTH variants checked against hand values.
module tb_fwd_sel_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [95:0] in_data;
  logic [1:0]  sel;
  logic        in_valid, in_ready, flush, out_ready;
  logic [31:0] out_data;
  logic        out_valid, sel_err, err_clr;
  logic [7:0]  err_count;

  logic        h_ready, h_valid, h_err;
  logic [31:0] h_data;
  logic [7:0]  h_cnt;

  logic        zero, one;
  logic        sw_valid;
  logic [39:0] d5;
  logic [2:0]  s5;
  logic [7:0]  o5, c5;
  logic        r5, v5, e5;
  logic [31:0] d4;
  logic [1:0]  s4;
  logic [7:0]  o4, c4;
  logic        r4, v4, e4;
  logic [127:0] d2;
  logic [0:0]  s2;
  logic [63:0] o2;
  logic [7:0]  c2;
  logic        r2, v2, e2;

  int n_assert = 0;
  int n_fail   = 0;

  fwd_sel_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err),
    .err_clr(err_clr), .err_count(err_count)
  );

  fwd_sel_pipe #(.HOLD_INVALID(1'b0)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(h_ready), .flush(flush),
    .out_data(h_data), .out_valid(h_valid),
    .out_ready(out_ready), .sel_err(h_err),
    .err_clr(err_clr), .err_count(h_cnt)
  );

  fwd_sel_pipe #(.NUM_IN(5), .WIDTH(8)) dut_n5 (
    .clk(clk), .rst_n(rst_n), .in_data(d5), .sel(s5),
    .in_valid(sw_valid), .in_ready(r5), .flush(zero),
    .out_data(o5), .out_valid(v5), .out_ready(one),
    .sel_err(e5), .err_clr(zero), .err_count(c5)
  );

  fwd_sel_pipe #(.NUM_IN(4), .WIDTH(8)) dut_n4 (
    .clk(clk), .rst_n(rst_n), .in_data(d4), .sel(s4),
    .in_valid(sw_valid), .in_ready(r4), .flush(zero),
    .out_data(o4), .out_valid(v4), .out_ready(one),
    .sel_err(e4), .err_clr(zero), .err_count(c4)
  );

  fwd_sel_pipe #(.NUM_IN(2), .WIDTH(64)) dut_n2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .sel(s2),
    .in_valid(sw_valid), .in_ready(r2), .flush(zero),
    .out_data(o2), .out_valid(v2), .out_ready(one),
    .sel_err(e2), .err_clr(zero), .err_count(c2)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] A0 = 32'h11111111;
  localparam logic [31:0] A1 = 32'h22222222;
  localparam logic [31:0] A2 = 32'h33333333;

  logic [7:0]  e5d, lg5, e4d;
  logic [63:0] e2d;

  initial begin
    rst_n = 1'b0; in_data = {A2, A1, A0}; sel = 2'd0;
    in_valid = 0; flush = 0; out_ready = 0; err_clr = 0;
    zero = 0; one = 1; sw_valid = 0;
    d5 = 40'h5544332211; s5 = 0;
    d4 = 32'hd4c3b2a1;   s4 = 0;
    d2 = {64'hfedcba9876543210, 64'h0123456789abcdef}; s2 = 0;
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", sel_err, 0);
    chk("rst_cnt", err_count, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;

    in_valid = 1; out_ready = 1;
    sel = 2'd0; cycle();
    chk("seq0", out_data, A0); chk("seq0_v", out_valid, 1);
    sel = 2'd1; cycle();
    chk("seq1", out_data, A1); chk("seq1_v", out_valid, 1);
    sel = 2'd2; cycle();
    chk("seq2", out_data, A2); chk("seq2_v", out_valid, 1);

    sel = 2'd1; cycle();
    chk("stall_ld", out_data, A1);
    out_ready = 0; sel = 2'd2; #1;
    chk("stall_rdy", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_data", out_data, A1);
      chk("stall_v", out_valid, 1);
    end
    out_ready = 1; #1;
    chk("rel_rdy", in_ready, 1);
    cycle();
    chk("rel_data", out_data, A2);

    sel = 2'd3; cycle();
    chk("oor_data", out_data, A2);
    chk("oor_v", out_valid, 1);
    chk("oor_err", sel_err, 1);
    chk("oor_cnt", err_count, 1);
    chk("h0_data", h_data, 0);
    chk("h0_err", h_err, 1);

    sel = 2'd0; flush = 1; cycle();
    chk("fl_v", out_valid, 0);
    chk("fl_cnt", err_count, 1);
    chk("fl_data", out_data, A2);
    flush = 0; cycle();
    chk("fl_after", out_data, A0);
    out_ready = 0; flush = 1; cycle();
    chk("flst_v", out_valid, 0);
    flush = 0; out_ready = 1; in_valid = 0; cycle();
    chk("flst_idle", out_valid, 0);

    in_valid = 1; sel = 2'd1; cycle();
    chk("cons_ld", out_data, A1);
    in_valid = 0; sel = 2'd2; in_data = '1; cycle();
    chk("cons_v", out_valid, 0);
    chk("cons_data", out_data, A1);
    sel = 2'd0; in_data = 96'h0; cycle();
    chk("idle_data", out_data, A1);
    in_data = {A2, A1, A0};

    in_valid = 1; sel = 2'd3;
    repeat (300) cycle();
    chk("sat_cnt", err_count, 8'd255);
    chk("sat_data", out_data, A1);
    chk("sat_h0", h_data, 0);
    in_valid = 0; err_clr = 1; cycle();
    chk("clr_cnt", err_count, 0);
    chk("clr_err", sel_err, 0);
    in_valid = 1; cycle();
    chk("clrw_cnt", err_count, 1);
    chk("clrw_err", sel_err, 1);
    err_clr = 0;

    sel = 2'd0; cycle();
    chk("ar_ld", out_data, A0);
    out_ready = 0; #2;
    rst_n = 0; #1;
    chk("ar_v", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_cnt", err_count, 0);
    chk("ar_rdy", in_ready, 1);
    in_valid = 0; rst_n = 1;
    cycle();
    chk("ar_idle", out_valid, 0);

    sw_valid = 1; lg5 = 8'h00;
    for (int s = 0; s < 8; s++) begin
      s5 = 3'(s); s4 = 2'(s); s2 = 1'(s);
      cycle();
      if (s < 5) begin
        e5d = 8'(8'h11 * (s + 1));
        lg5 = e5d;
      end else begin
        e5d = lg5;
      end
      e4d = 8'(8'ha1 + 8'h11 * (s % 4));
      e2d = (s % 2) ? 64'hfedcba9876543210 : 64'h0123456789abcdef;
      chk("n5_data", o5, e5d);
      chk("n4_data", o4, e4d);
      chk("n2_data", o2, e2d);
    end
    chk("n5_cnt", c5, 3);
    chk("n5_err", e5, 1);
    chk("n4_cnt", c4, 0);
    chk("n2_err", e2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
